// File: rtl/icg_ctrl_pkg.sv
// Shared types for the ICG enable sequencer: FSM state enum and STATE encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icg_ctrl_pkg;

  // Encodings driven on the STATE debug port.
  localparam logic [1:0] ST_ENC_OFF  = 2'd0;
  localparam logic [1:0] ST_ENC_WAKE = 2'd1;
  localparam logic [1:0] ST_ENC_ON   = 2'd2;
  localparam logic [1:0] ST_ENC_IDLE = 2'd3;

  typedef enum logic [1:0] {
    S_OFF  = ST_ENC_OFF,
    S_WAKE = ST_ENC_WAKE,
    S_ON   = ST_ENC_ON,
    S_IDLE = ST_ENC_IDLE
  } icg_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/icg_ctrl_cnt.sv
// Loadable saturating up-counter with terminal compare, shared by WAKE and IDLE.
// Latency: load/increment visible one cycle later; tc_o is combinational on the current count.
// Backpressure: none; load has priority over increment, increment stops at all-ones.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/load_val_i reload;
//        inc_i count enable; term_i compare value; tc_o high while count == term_i.
module icg_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/icg_enable_ctrl.sv
// Enable sequencer for a negative-clock ICG: opens on request, acks after a settle time, closes after idle run.
// Latency: E rises one edge after REQ is sampled in OFF; ACK follows WAKE_CYCLES edges later.
// Backpressure: REQ/BUSY are levels; REQ changes during WAKE are ignored, BUSY holds the gate open but never wakes it.
// Ports: CLK free-running clock; RN async active-low reset; REQ/BUSY client request/activity;
//        SE scan enable; E/ACK registered gate enable and clock-valid; TE = SE; STATE debug state;
//        FORCE_ON only exists when ICG_CTRL_FORCE_ON_EN is defined.
module icg_enable_ctrl
  import icg_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       REQ,
  input  logic       BUSY,
  input  logic       SE,
  output logic       E,
  output logic       TE,
  output logic       ACK,
  output logic [1:0] STATE
`ifdef ICG_CTRL_FORCE_ON_EN
  ,
  input  logic       FORCE_ON
`endif
);

  localparam int CW = $clog2(max_int(IDLE_CYCLES, WAKE_CYCLES) + 1);

  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] WAKE_TERM = CW'(WAKE_CYCLES);
  localparam logic [CW-1:0] IDLE_TERM = CW'(IDLE_CYCLES - 1);

  icg_state_t    state_q;
  icg_state_t    state_d;
  logic          e_q;
  logic          e_d;
  logic          ack_q;
  logic          ack_d;

  logic          force_on;
  logic          wake_req;
  logic          idle;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_inc;
  logic [CW-1:0] cnt_term;
  logic          cnt_tc;

`ifdef ICG_CTRL_FORCE_ON_EN
  assign force_on = FORCE_ON;
`else
  assign force_on = 1'b0;
`endif

  assign wake_req = REQ | force_on;
  // BUSY and FORCE_ON keep the gate open, but only REQ/FORCE_ON can wake it.
  assign idle     = ~(REQ | BUSY | force_on);

  icg_ctrl_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RN),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .term_i     (cnt_term),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = CNT_ZERO;
    cnt_inc      = 1'b0;
    cnt_term     = CNT_ZERO;
    case (state_q)
      S_OFF: begin
        if (wake_req) begin
          state_d      = S_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_ONE;
        end
      end
      S_WAKE: begin
        cnt_term = WAKE_TERM;
        if (cnt_tc) begin
          state_d  = S_ON;
          cnt_load = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_ON: begin
        if (idle) begin
          cnt_load = 1'b1;
          if (IDLE_CYCLES == 1) begin
            state_d = S_OFF;
          end else begin
            state_d      = S_IDLE;
            cnt_load_val = CNT_ONE;
          end
        end
      end
      S_IDLE: begin
        // The first idle edge was taken in ON, so the count expires at IDLE_CYCLES-1.
        cnt_term = IDLE_TERM;
        if (!idle) begin
          state_d  = S_ON;
          cnt_load = 1'b1;
        end else if (cnt_tc) begin
          state_d  = S_OFF;
          cnt_load = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d  = S_OFF;
        cnt_load = 1'b1;
      end
    endcase
  end

  // Outputs registered from the next state so E only moves just after a rising edge.
  always_comb begin
    e_d   = (state_d != S_OFF);
    ack_d = (state_d == S_ON) || (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_OFF;
      e_q     <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
    end
  end

  assign E     = e_q;
  assign ACK   = ack_q;
  assign STATE = state_q;
  // Scan shift must always reach the gated domain, independent of reset and FSM.
  assign TE    = SE;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
module tb_icg_enable_ctrl;

  logic       CLK;
  logic       RN;
  logic       req_a, busy_a, se_a;
  logic       e_a, te_a, ack_a;
  logic [1:0] state_a;
  logic       req_b, busy_b, se_b;
  logic       e_b, te_b, ack_b;
  logic [1:0] state_b;
  logic       force_a, force_b;

  int ntests = 0;
  int nfail  = 0;

  icg_enable_ctrl #(
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2)
  ) dut_a (
    .CLK      (CLK),
    .RN       (RN),
    .REQ      (req_a),
    .BUSY     (busy_a),
    .SE       (se_a),
    .E        (e_a),
    .TE       (te_a),
    .ACK      (ack_a),
    .STATE    (state_a)
`ifdef ICG_CTRL_FORCE_ON_EN
    ,
    .FORCE_ON (force_a)
`endif
  );

  icg_enable_ctrl #(
    .IDLE_CYCLES (1),
    .WAKE_CYCLES (1)
  ) dut_b (
    .CLK      (CLK),
    .RN       (RN),
    .REQ      (req_b),
    .BUSY     (busy_b),
    .SE       (se_b),
    .E        (e_b),
    .TE       (te_b),
    .ACK      (ack_b),
    .STATE    (state_b)
`ifdef ICG_CTRL_FORCE_ON_EN
    ,
    .FORCE_ON (force_b)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] st, input logic e, input logic ack);
    chk({tag, ".state"}, {6'd0, state_a}, {6'd0, st});
    chk({tag, ".E"},     {7'd0, e_a},     {7'd0, e});
    chk({tag, ".ACK"},   {7'd0, ack_a},   {7'd0, ack});
  endtask

  task automatic chk_b(input string tag, input logic [1:0] st, input logic e, input logic ack);
    chk({tag, ".state"}, {6'd0, state_b}, {6'd0, st});
    chk({tag, ".E"},     {7'd0, e_b},     {7'd0, e});
    chk({tag, ".ACK"},   {7'd0, ack_b},   {7'd0, ack});
  endtask

  initial begin
    RN = 1'b0;
    req_a = 1'b0; busy_a = 1'b0; se_a = 1'b0; force_a = 1'b0;
    req_b = 1'b0; busy_b = 1'b0; se_b = 1'b0; force_b = 1'b0;

    // Reset state and TE pass-through during reset.
    #1;
    chk_a("rst", 2'd0, 1'b0, 1'b0);
    chk("rst.TE0", {7'd0, te_a}, 8'd0);
    se_a = 1'b1;
    #1;
    chk("rst.TE1", {7'd0, te_a}, 8'd1);
    chk("rst.E_se", {7'd0, e_a}, 8'd0);
    se_a = 1'b0;
    #1;
    RN = 1'b1;

    // Stays OFF with no request; BUSY alone does not wake.
    step(); step();
    chk_a("off_hold", 2'd0, 1'b0, 1'b0);
    busy_a = 1'b1;
    step();
    chk_a("busy_off", 2'd0, 1'b0, 1'b0);
    busy_a = 1'b0;

    // Scan enable in OFF.
    se_a = 1'b1;
    #1;
    chk("scan_off.TE1", {7'd0, te_a}, 8'd1);
    chk("scan_off.E", {7'd0, e_a}, 8'd0);
    se_a = 1'b0;
    #1;
    chk("scan_off.TE0", {7'd0, te_a}, 8'd0);

    // Wake: REQ dropped during WAKE is ignored.
    req_a = 1'b1;
    step();
    chk_a("wake0", 2'd1, 1'b1, 1'b0);
    req_a = 1'b0;
    step();
    chk_a("wake1", 2'd1, 1'b1, 1'b0);
    step();
    chk_a("wake2", 2'd2, 1'b1, 1'b1);

    // Idle close after 4 idle edges.
    step(); chk_a("idle1", 2'd3, 1'b1, 1'b1);
    step(); chk_a("idle2", 2'd3, 1'b1, 1'b1);
    step(); chk_a("idle3", 2'd3, 1'b1, 1'b1);
    step(); chk_a("idle4", 2'd0, 1'b0, 1'b0);

    // BUSY hold from IDLE with count 2.
    req_a = 1'b1;
    step(); step(); step();
    chk_a("bh_on", 2'd2, 1'b1, 1'b1);
    req_a = 1'b0;
    step(); step();
    chk_a("bh_idle2", 2'd3, 1'b1, 1'b1);
    busy_a = 1'b1;
    step();
    chk_a("bh_busy", 2'd2, 1'b1, 1'b1);
    busy_a = 1'b0;
    step(); step(); step();
    chk_a("bh_idle3", 2'd3, 1'b1, 1'b1);
    step();
    chk_a("bh_close", 2'd0, 1'b0, 1'b0);

    // REQ on the expiring edge keeps the gate open.
    req_a = 1'b1;
    step(); step(); step();
    req_a = 1'b0;
    step(); step(); step();
    chk_a("exp_idle3", 2'd3, 1'b1, 1'b1);
    req_a = 1'b1;
    step();
    chk_a("exp_req", 2'd2, 1'b1, 1'b1);
    req_a = 1'b0;
    step(); step(); step(); step();
    chk_a("exp_close", 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-IDLE.
    req_a = 1'b1;
    step(); step(); step();
    req_a = 1'b0;
    step();
    chk_a("mid_idle", 2'd3, 1'b1, 1'b1);
    #2;
    RN = 1'b0;
    #1;
    chk_a("arst", 2'd0, 1'b0, 1'b0);
    se_a = 1'b1;
    #1;
    chk("arst.TE", {7'd0, te_a}, 8'd1);
    se_a = 1'b0;
    #1;
    RN = 1'b1;
    step(); step();
    chk_a("post_rst", 2'd0, 1'b0, 1'b0);

    // IDLE_CYCLES=1, WAKE_CYCLES=1: one-cycle REQ pulse.
    req_b = 1'b1;
    step();
    chk_b("b_wake", 2'd1, 1'b1, 1'b0);
    req_b = 1'b0;
    step();
    chk_b("b_on", 2'd2, 1'b1, 1'b1);
    step();
    chk_b("b_off", 2'd0, 1'b0, 1'b0);
    step();
    chk_b("b_stay", 2'd0, 1'b0, 1'b0);

`ifdef ICG_CTRL_FORCE_ON_EN
    force_b = 1'b1;
    step();
    chk_b("f_wake", 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_b("f_hold", 2'd2, 1'b1, 1'b1);
    end
    force_b = 1'b0;
    step();
    chk_b("f_off", 2'd0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
